gray_ptr_sync_ble: RTL and testbench
====================================

Name: gray_ptr_sync_ble

Overview:
- Parametrised N-stage synchronizer for Gray-coded FIFO pointers crossing into the local clock domain.
- Successor to the fixed 2-flop pointer synchronizer used by the BLE PHY async FIFOs.
- Adds configurable depth, registered Gray-to-binary conversion, update strobe and pointer delta.
- Adds an optional Gray-code violation checker.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; pointer width is ADDR_WIDTH+1.
- SYNC_STAGES, 2, synchronizer flop count; legal 2..4; any other value is a generate-time elaboration error.
- RESET_VAL, 0, Gray value loaded into every sync stage on reset.

Ports:
- W_CLK  in  1  local (destination) clock.
- W_rst  in  1  asynchronous, active-high reset.
- R_ptr  in  ADDR_WIDTH+1  Gray-coded pointer from the source domain; asynchronous to W_CLK.
- err_clr  in  1  synchronous clear of the violation counter.
- Wq_rptr  out  ADDR_WIDTH+1  synchronized Gray pointer (last sync stage).
- Wq_rptr_bin  out  ADDR_WIDTH+1  registered binary equivalent of Wq_rptr.
- Wq_rptr_upd  out  1  one-cycle pulse when the synchronized pointer changed.
- Wq_rptr_delta  out  ADDR_WIDTH+1  binary advance since the previous value, modulo 2^(ADDR_WIDTH+1).
- gray_err  out  1  one-cycle pulse on a multi-bit Gray change.
- gray_err_cnt  out  8  saturating violation count.

Behaviour:
- Clocking and reset:
  - One clock, W_CLK. Reset is asynchronous and active-high (W_rst).
  - All flops are reset asynchronously.
- Reset values:
  - Every sync stage and Wq_rptr = RESET_VAL.
  - Wq_rptr_bin = gray2bin(RESET_VAL).
  - Wq_rptr_upd = 0, Wq_rptr_delta = 0, gray_err = 0, gray_err_cnt = 0.
- Sync chain:
  - stage[0] <= R_ptr; stage[i] <= stage[i-1].
  - Wq_rptr = stage[SYNC_STAGES-1].
  - Latency: a stable R_ptr appears on Wq_rptr after SYNC_STAGES W_CLK edges.
  - No combinational logic is allowed between stages or in front of stage[0].
- Post stage (one extra register, latency SYNC_STAGES+1):
  - prev_gray holds the Wq_rptr value from the previous cycle; reset = RESET_VAL.
  - Wq_rptr_bin <= gray2bin(Wq_rptr), where bin[MSB] = g[MSB] and bin[i] = bin[i+1] ^ g[i].
  - Wq_rptr_upd <= (Wq_rptr != prev_gray).
  - Wq_rptr_delta <= gray2bin(Wq_rptr) - gray2bin(prev_gray), truncated to ADDR_WIDTH+1 bits.
  - Wrap-around is natural: e.g. 31 -> 0 gives delta 1.
  - When no change occurs: upd = 0 and delta = 0 in that cycle.
- Multi-step advance:
  - If the source skips values between sample points (slow W_CLK), delta reports the full advance.
  - upd still pulses only once.
- Reset mid-operation:
  - All outputs return to reset values in the same cycle (asynchronous).
  - No upd pulse occurs on the first post-reset cycle unless R_ptr differs from RESET_VAL.
  - The normal latency rule applies after reset.

Optional Feature:
- Macro: GRAY_PTR_SYNC_CHECK_EN.
- Defined:
  - gray_err <= (popcount(Wq_rptr ^ prev_gray) > 1); the pulse is aligned with Wq_rptr_upd.
  - gray_err_cnt increments on each gray_err and saturates at 255.
  - err_clr forces the count to 0. If err_clr and gray_err occur in the same cycle, the count becomes 1.
- Undefined:
  - gray_err and gray_err_cnt are tied to 0; err_clr is ignored.
  - No checker logic is synthesized.

Test Plan:
- Reset: assert W_rst mid-stream with R_ptr=5'b00110 -> all outputs at reset values immediately; after release with R_ptr held, Wq_rptr=5'b00110 after exactly 2 edges, upd pulses one cycle later, Wq_rptr_bin=5'd4, delta=4.
- Increment stream: R_ptr Gray sequence for 0..31 -> bin 0..31, one upd per step, delta=1 each step; wrap 31->0 gives delta=1.
- Latency sweep: SYNC_STAGES=3 and 4 -> Wq_rptr follows R_ptr after 3 or 4 edges; bin and upd follow one cycle later.
- Skip: R_ptr jumps Gray(3) -> Gray(7) between samples -> single upd, delta=4, gray_err=1 with checker enabled.
- Checker: inject 300 multi-bit changes -> gray_err_cnt saturates at 255; err_clr together with a violation -> count=1; err_clr alone -> 0.
- Macro off: same violations -> gray_err=0, gray_err_cnt=0, while sync outputs are identical to the macro-on run.

Source files
------------

// File: rtl/gray_ptr_sync_ble.sv
// rtl/gray_ptr_sync_ble.sv - N-stage Gray pointer synchronizer with binary/update/delta post stage
// Optional Gray violation checker enabled by defining GRAY_PTR_SYNC_CHECK_EN.
module gray_ptr_sync_ble #(
    parameter int                  ADDR_WIDTH  = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [ADDR_WIDTH:0] RESET_VAL   = '0
) (
    input  logic                  W_CLK,
    input  logic                  W_rst,
    input  logic [ADDR_WIDTH:0]   R_ptr,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   Wq_rptr,
    output logic [ADDR_WIDTH:0]   Wq_rptr_bin,
    output logic                  Wq_rptr_upd,
    output logic [ADDR_WIDTH:0]   Wq_rptr_delta,
    output logic                  gray_err,
    output logic [7:0]            gray_err_cnt
);

    localparam int PW = ADDR_WIDTH + 1;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("gray_ptr_sync_ble: SYNC_STAGES must be 2..4");
        end
    endgenerate

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pure flop chain: nothing combinational ahead of or between stages.
    logic [PW-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge W_CLK or posedge W_rst) begin
        if (W_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= R_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign Wq_rptr = sync_q[SYNC_STAGES-1];

    logic [PW-1:0] prev_gray_q;
    logic [PW-1:0] bin_q, bin_d;
    logic          upd_q, upd_d;
    logic [PW-1:0] delta_q, delta_d;
    logic [PW-1:0] prev_bin;

    always_comb begin
        bin_d    = gray2bin(Wq_rptr);
        prev_bin = gray2bin(prev_gray_q);
        upd_d    = (Wq_rptr != prev_gray_q);
        delta_d  = bin_d - prev_bin;
    end

    always_ff @(posedge W_CLK or posedge W_rst) begin
        if (W_rst) begin
            prev_gray_q <= RESET_VAL;
            bin_q       <= gray2bin(RESET_VAL);
            upd_q       <= 1'b0;
            delta_q     <= '0;
        end else begin
            prev_gray_q <= Wq_rptr;
            bin_q       <= bin_d;
            upd_q       <= upd_d;
            delta_q     <= delta_d;
        end
    end

    assign Wq_rptr_bin   = bin_q;
    assign Wq_rptr_upd   = upd_q;
    assign Wq_rptr_delta = delta_q;

`ifdef GRAY_PTR_SYNC_CHECK_EN
    logic [PW-1:0] diff;
    logic          gray_err_q, gray_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // Clearing the lowest set bit leaves something only if two or more bits flipped.
    always_comb begin
        diff       = Wq_rptr ^ prev_gray_q;
        gray_err_d = |(diff & (diff - PW'(1)));
        err_cnt_d  = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = {7'd0, gray_err_d};
        end else if (gray_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge W_CLK or posedge W_rst) begin
        if (W_rst) begin
            gray_err_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            gray_err_q <= gray_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign gray_err     = gray_err_q;
    assign gray_err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign gray_err       = 1'b0;
    assign gray_err_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_ble.sv
// tb/tb_gray_ptr_sync_ble.sv - randomized check of gray_ptr_sync_ble at 2, 3 and 4 sync stages
module tb_gray_ptr_sync_ble;

    localparam int PW = 5;
    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] r_ptr;
    logic          err_clr;

    logic [PW-1:0] wq    [ND];
    logic [PW-1:0] bin   [ND];
    logic          upd   [ND];
    logic [PW-1:0] delta [ND];
    logic          gerr  [ND];
    logic [7:0]    gcnt  [ND];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        gray_ptr_sync_ble #(.ADDR_WIDTH(4), .SYNC_STAGES(gi + 2), .RESET_VAL(5'd0)) u_dut (
            .W_CLK        (clk),
            .W_rst        (rst),
            .R_ptr        (r_ptr),
            .err_clr      (err_clr),
            .Wq_rptr      (wq[gi]),
            .Wq_rptr_bin  (bin[gi]),
            .Wq_rptr_upd  (upd[gi]),
            .Wq_rptr_delta(delta[gi]),
            .gray_err     (gerr[gi]),
            .gray_err_cnt (gcnt[gi])
        );
    end

    int checks   = 0;
    int failures = 0;

    // Model: history of R_ptr applied before each edge since reset release.
    logic [PW-1:0] hist  [0:4095];
    bit            clr_h [0:4095];
    int            m;
    int            cnt_m [ND];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input logic [PW-1:0] g);
        for (int b = 0; b < 32; b++) begin
            if (gray_of(b) == int'(g)) return b;
        end
        return -1;
    endfunction

    function automatic int popc(input logic [PW-1:0] x);
        int n = 0;
        for (int i = 0; i < PW; i++) n += int'(x[i]);
        return n;
    endfunction

    // Synchronized value after edge k for an s-stage chain: input from s-1 edges earlier.
    function automatic logic [PW-1:0] wq_at(input int s, input int k);
        int idx = k - s + 1;
        return (idx >= 1) ? hist[idx] : 5'd0;
    endfunction

    task automatic check_reset(input string tag);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_wq%0d", tag, d),    32'(wq[d]),    0);
            check($sformatf("%s_bin%0d", tag, d),   32'(bin[d]),   0);
            check($sformatf("%s_upd%0d", tag, d),   32'(upd[d]),   0);
            check($sformatf("%s_delta%0d", tag, d), 32'(delta[d]), 0);
            check($sformatf("%s_err%0d", tag, d),   32'(gerr[d]),  0);
            check($sformatf("%s_cnt%0d", tag, d),   32'(gcnt[d]),  0);
        end
    endtask

    task automatic step(input logic [PW-1:0] r, input bit c);
        logic [PW-1:0] cur, prv;
        int            s, e_err, e_cnt;
        bit            err;
        r_ptr   = r;
        err_clr = c;
        m++;
        hist[m]  = r;
        clr_h[m] = c;
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            s   = d + 2;
            cur = wq_at(s, m - 1);
            prv = wq_at(s, m - 2);
            err = popc(cur ^ prv) > 1;
            if (clr_h[m])                       cnt_m[d] = err ? 1 : 0;
            else if (err && cnt_m[d] < 255)     cnt_m[d]++;
`ifdef GRAY_PTR_SYNC_CHECK_EN
            e_err = int'(err);
            e_cnt = cnt_m[d];
`else
            e_err = 0;
            e_cnt = 0;
`endif
            check($sformatf("wq_s%0d", s),    32'(wq[d]),    32'(wq_at(s, m)));
            check($sformatf("bin_s%0d", s),   32'(bin[d]),   32'(g2b(cur)));
            check($sformatf("upd_s%0d", s),   32'(upd[d]),   32'(cur != prv));
            check($sformatf("delta_s%0d", s), 32'(delta[d]), 32'((g2b(cur) - g2b(prv)) & 31));
            check($sformatf("err_s%0d", s),   32'(gerr[d]),  32'(e_err));
            check($sformatf("cnt_s%0d", s),   32'(gcnt[d]),  32'(e_cnt));
        end
    endtask

    task automatic model_reset();
        m = 0;
        for (int d = 0; d < ND; d++) cnt_m[d] = 0;
    endtask

    initial begin
        int v;
        rst     = 1'b1;
        r_ptr   = '0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        model_reset();

        // Increment stream through full wrap with random hold times.
        for (int i = 0; i <= 33; i++) begin
            v = gray_of(i % 32);
            repeat ($urandom_range(1, 3)) step(PW'(v), 1'b0);
        end

        // Skip Gray(3) -> Gray(7).
        repeat (5) step(PW'(gray_of(3)), 1'b0);
        repeat (6) step(PW'(gray_of(7)), 1'b0);

        // 300 two-bit violations to saturate the counter.
        for (int i = 0; i < 300; i++) step((i % 2) ? 5'b00011 : 5'b00000, 1'b0);
        step(5'b00000, 1'b1);
        step(5'b00011, 1'b0);
        repeat (6) step(5'b00011, 1'b0);
        step(5'b00011, 1'b1);
        repeat (3) step(5'b00011, 1'b0);

        // Asynchronous reset mid-stream with R_ptr = 5'b00110.
        step(5'b01100, 1'b0);
        r_ptr = 5'b00110;
        rst   = 1'b1;
        #2;
        check_reset("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (8) step(5'b00110, 1'b0);

        // Randomized traffic: mostly legal advances, some skips and jumps.
        v = 4;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 31);
            else                           v = (v + $urandom_range(0, 2)) % 32;
            step(PW'(gray_of(v)), ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
